// File: rtl/iob_plic2_if.sv
// IOb register-window bus bundle for iob_plic2: request fields driven by the master,
// ready/rvalid/rdata returned by the slave.
interface iob_plic2_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic                  iob_avalid;
    logic [ADDR_W-1:0]     iob_addr;
    logic [DATA_W-1:0]     iob_wdata;
    logic [DATA_W/8-1:0]   iob_wstrb;
    logic                  iob_ready;
    logic                  iob_rvalid;
    logic [DATA_W-1:0]     iob_rdata;

    modport master (
        output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_ready, iob_rvalid, iob_rdata
    );

    modport slave (
        input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
        output iob_ready, iob_rvalid, iob_rdata
    );
endinterface

// File: rtl/iob_plic2.sv
// Platform interrupt controller: gateways, per-target arbitration, claim/complete (IOB_PLIC2_EDGE_CNT_EN: queued edges).
// Latency: src_i to irq_o 3 cycles; register reads return 1 cycle after the request.
// Backpressure: none, ready is tied high and every request is accepted in its cycle.
module iob_plic2 #(
    parameter int N_SOURCES         = 8,
    parameter int N_TARGETS         = 2,
    parameter int PRIORITIES        = 8,
    parameter int MAX_PENDING_COUNT = 4,
    parameter int DATA_W            = 32,
    parameter int ADDR_W            = 9
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    iob_plic2_if.slave           bus,
    input  logic [N_SOURCES-1:0] src_i,
    output logic [N_TARGETS-1:0] irq_o
);
    localparam int PB     = $clog2(PRIORITIES);
    localparam int IW     = 5;
    localparam int W_EL   = 0;
    localparam int W_IP   = 1;
    localparam int W_PRIO = 16;
    localparam int W_IE   = 64;
    localparam int W_TH   = 80;
    localparam int W_CC   = 96;
`ifdef IOB_PLIC2_EDGE_CNT_EN
    localparam int CNT_MAX = MAX_PENDING_COUNT;
`else
    localparam int CNT_MAX = (MAX_PENDING_COUNT > 1) ? 1 : MAX_PENDING_COUNT;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef logic [PB-1:0] prio_t;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [IW-1:0] id_t;

    logic [N_SOURCES-1:0] el_q, el_d, src_q, ip_q, ip_d, ins_q, ins_d;
    prio_t                prio_q [N_SOURCES];
    prio_t                prio_d [N_SOURCES];
    cnt_t                 cnt_q  [N_SOURCES];
    cnt_t                 cnt_d  [N_SOURCES];
    logic [N_SOURCES-1:0] ie_q   [N_TARGETS];
    logic [N_SOURCES-1:0] ie_d   [N_TARGETS];
    prio_t                th_q   [N_TARGETS];
    prio_t                th_d   [N_TARGETS];
    id_t                  id_q   [N_TARGETS];
    id_t                  id_d   [N_TARGETS];
    logic [N_TARGETS-1:0] irq_q, irq_d;
    logic                 rvalid_q, rvalid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    int                   widx;
    logic                 is_rd, is_wr;
    id_t                  claim_id, cmpl_id;
    logic [N_SOURCES-1:0] rise, claim_hit, cmpl_hit, dec_hit;
    prio_t                arb_prio [N_TARGETS];
    id_t                  arb_id   [N_TARGETS];
    logic                 unused_addr;

    function automatic logic [31:0] wr_merge(input logic [31:0] cur, input logic [31:0] wd,
                                             input logic [3:0] st);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++)
            if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    assign widx        = int'(bus.iob_addr[ADDR_W-1:2]);
    assign is_rd       = bus.iob_avalid && (bus.iob_wstrb == '0);
    assign is_wr       = bus.iob_avalid && (bus.iob_wstrb != '0);
    assign unused_addr = ^bus.iob_addr[1:0];

    // Register window: reads of CC are claims, writes of CC are completes.
    always_comb begin
        el_d     = el_q;
        prio_d   = prio_q;
        ie_d     = ie_q;
        th_d     = th_q;
        rdata_d  = rdata_q;
        rvalid_d = is_rd;
        claim_id = '0;
        cmpl_id  = '0;
        if (is_rd) begin
            rdata_d = '0;
            if (widx == W_EL) rdata_d = DATA_W'(el_q);
            if (widx == W_IP) rdata_d = DATA_W'(ip_q);
            for (int k = 0; k < N_SOURCES; k++)
                if (widx == W_PRIO + k) rdata_d = DATA_W'(prio_q[k]);
            for (int t = 0; t < N_TARGETS; t++) begin
                if (widx == W_IE + t) rdata_d = DATA_W'(ie_q[t]);
                if (widx == W_TH + t) rdata_d = DATA_W'(th_q[t]);
                if (widx == W_CC + t) begin
                    rdata_d  = DATA_W'(id_q[t]);
                    claim_id = id_q[t];
                end
            end
        end
        if (is_wr) begin
            if (widx == W_EL)
                el_d = N_SOURCES'(wr_merge(32'(el_q), bus.iob_wdata, bus.iob_wstrb));
            for (int k = 0; k < N_SOURCES; k++)
                if (widx == W_PRIO + k)
                    prio_d[k] = PB'(wr_merge(32'(prio_q[k]), bus.iob_wdata, bus.iob_wstrb));
            for (int t = 0; t < N_TARGETS; t++) begin
                if (widx == W_IE + t)
                    ie_d[t] = N_SOURCES'(wr_merge(32'(ie_q[t]), bus.iob_wdata, bus.iob_wstrb));
                if (widx == W_TH + t)
                    th_d[t] = PB'(wr_merge(32'(th_q[t]), bus.iob_wdata, bus.iob_wstrb));
                if (widx == W_CC + t)
                    cmpl_id = bus.iob_wdata[IW-1:0];
            end
        end
    end

    // Gateways. ip uses next-cycle in-service so a claim drops irq_o two edges later.
    always_comb begin
        rise      = src_i & ~src_q;
        claim_hit = '0;
        cmpl_hit  = '0;
        dec_hit   = '0;
        cnt_d     = cnt_q;
        for (int k = 0; k < N_SOURCES; k++) begin
            claim_hit[k] = (claim_id == id_t'(k + 1));
            cmpl_hit[k]  = (cmpl_id == id_t'(k + 1)) && ins_q[k];
        end
        ins_d = (ins_q | claim_hit) & ~cmpl_hit;
        for (int k = 0; k < N_SOURCES; k++) begin
            dec_hit[k] = claim_hit[k] && !ins_q[k] && (cnt_q[k] != '0);
            if (el_q[k]) begin
                if (rise[k] && !claim_hit[k] && (cnt_q[k] != cnt_t'(CNT_MAX)))
                    cnt_d[k] = cnt_q[k] + 1'b1;
                else if (dec_hit[k] && !rise[k])
                    cnt_d[k] = cnt_q[k] - 1'b1;
            end
            if (el_d[k] != el_q[k]) cnt_d[k] = '0;
            ip_d[k] = (el_q[k] ? (cnt_q[k] != '0) : src_q[k]) & ~ins_d[k];
        end
    end

    // Strict '>' keeps the lowest ID on priority ties and excludes priority 0.
    always_comb begin
        for (int t = 0; t < N_TARGETS; t++) begin
            arb_prio[t] = '0;
            arb_id[t]   = '0;
            for (int k = 0; k < N_SOURCES; k++) begin
                if (ip_q[k] && ie_q[t][k] && (prio_q[k] > arb_prio[t])) begin
                    arb_prio[t] = prio_q[k];
                    arb_id[t]   = id_t'(k + 1);
                end
            end
            id_d[t]  = arb_id[t];
            irq_d[t] = (arb_id[t] != '0) && (arb_prio[t] > th_q[t]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            el_q     <= '0;
            src_q    <= '0;
            ip_q     <= '0;
            ins_q    <= '0;
            irq_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            for (int k = 0; k < N_SOURCES; k++) begin
                prio_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            for (int t = 0; t < N_TARGETS; t++) begin
                ie_q[t] <= '0;
                th_q[t] <= '0;
                id_q[t] <= '0;
            end
        end else begin
            el_q     <= el_d;
            src_q    <= src_i;
            ip_q     <= ip_d;
            ins_q    <= ins_d;
            irq_q    <= irq_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            prio_q   <= prio_d;
            cnt_q    <= cnt_d;
            ie_q     <= ie_d;
            th_q     <= th_d;
            id_q     <= id_d;
        end
    end

    assign bus.iob_ready  = 1'b1;
    assign bus.iob_rvalid = rvalid_q;
    assign bus.iob_rdata  = rdata_q;
    assign irq_o          = irq_q;
endmodule
